// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern driver.
// It produces OFF, BLINK, CHASE and BOUNCE patterns. The pattern steps at a
// programmable rate, and a global PWM brightness gates every channel.
// The leds and tick outputs are both registered.
module led_pattern_gen #(
    parameter int N_LEDS      = 8,
    parameter int TICK_CYCLES = 6000000,
    parameter int PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                mode_load,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [N_LEDS-1:0]   leds,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam int                DIV_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_CYCLES - 1);
    localparam logic [N_LEDS-1:0] ALL_ON   = {N_LEDS{1'b1}};
    localparam logic [N_LEDS-1:0] BIT0     = N_LEDS'(1);

    logic [DIV_W-1:0]    r_divider;
    logic                w_step;
    mode_t               r_mode;
    logic [N_LEDS-1:0]   r_pattern;
    logic                r_dir_down;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_bright;
    logic                w_pwm_on;

    assign w_step = (r_divider == DIV_LAST);

    // A full-scale brightness means 100 % duty. Any other value gives a
    // duty of r_bright out of 2^PWM_BITS cycles.
    assign w_pwm_on = (r_bright == {PWM_BITS{1'b1}}) || (r_pwm_cnt < r_bright);

    // Step divider. A mode load restarts the step period from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divider <= '0;
        end else if (mode_load || w_step) begin
            r_divider <= '0;
        end else begin
            r_divider <= r_divider + 1'b1;
        end
    end

    // tick is a one-cycle registered copy of the internal step strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= w_step;
        end
    end

    // Mode and pattern state. A load reinitialises the pattern and takes
    // priority over a step that falls on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_OFF;
            r_pattern  <= '0;
            r_dir_down <= 1'b0;
        end else if (mode_load) begin
            r_mode     <= mode_t'(mode);
            r_dir_down <= 1'b0;
            case (mode_t'(mode))
                MODE_OFF:   r_pattern <= '0;
                MODE_BLINK: r_pattern <= ALL_ON;
                default:    r_pattern <= BIT0;
            endcase
        end else if (w_step) begin
            case (r_mode)
                MODE_OFF: begin
                    r_pattern <= '0;
                end
                MODE_BLINK: begin
                    r_pattern <= ~r_pattern;
                end
                MODE_CHASE: begin
                    // Rotate left. With a single LED the rotation reduces to holding bit0.
                    r_pattern <= (r_pattern << 1) | (r_pattern >> (N_LEDS - 1));
                end
                default: begin
                    // Bounce: turn at either end with no dwell. A single LED just holds.
                    if (N_LEDS > 1) begin
                        if (!r_dir_down) begin
                            if (r_pattern[N_LEDS-1]) begin
                                r_pattern  <= r_pattern >> 1;
                                r_dir_down <= 1'b1;
                            end else begin
                                r_pattern <= r_pattern << 1;
                            end
                        end else begin
                            if (r_pattern[0]) begin
                                r_pattern  <= r_pattern << 1;
                                r_dir_down <= 1'b0;
                            end else begin
                                r_pattern <= r_pattern >> 1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Free-running PWM counter. Brightness is captured only at the start of
    // a period, so a mid-period change never produces a runt pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_cnt <= '0;
            r_bright  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_pwm_cnt == '0) begin
                r_bright <= brightness;
            end
        end
    end

    // Registered LED drive: the current pattern gated by the PWM phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= '0;
        end else begin
            leds <= r_pattern & {N_LEDS{w_pwm_on}};
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver and the successor to the fixed eight-LED half-second blinker. It generates runtime-selectable patterns (off, blink, chase, bounce) at a programmable step rate, with global PWM brightness. It sits between the board top-level and the LED pins. Control inputs come from game or debug logic.

Parameters:
N_LEDS, 8, number of LED channels (>=1)
TICK_CYCLES, 6000000, clk cycles per pattern step (0.5 s at 12 MHz); must be >=2
PWM_BITS, 4, brightness resolution; PWM period = 2^PWM_BITS cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mode  in  2  pattern select: 0 OFF, 1 BLINK, 2 CHASE, 3 BOUNCE
mode_load  in  1  one-cycle strobe; latches mode and restarts the pattern
brightness  in  PWM_BITS  global duty setting
leds  out  N_LEDS  registered LED drive, active-high
tick  out  1  registered one-cycle pulse at each pattern step

Behaviour:
- Reset is synchronous and active-high. On any clk edge with rst=1:
  - leds=0, tick=0, mode_r=OFF, pattern=0, dir=up
  - divider=0, pwm_cnt=0, bright_r=0
  - rst overrides mode_load and tick.
- Divider:
  - Width is $clog2(TICK_CYCLES).
  - Counts 0..TICK_CYCLES-1, then wraps to 0.
  - step is internal and true when divider==TICK_CYCLES-1.
  - tick is a registered copy of step, so it is high for exactly 1 cycle every TICK_CYCLES cycles.
- mode_load=1:
  - mode_r<=mode and divider<=0.
  - Pattern initialises as follows: OFF=0; BLINK=all ones; CHASE=bit0 set; BOUNCE=bit0 set, dir=up.
  - The pattern does not advance that cycle, even if step is true; load wins over step.
- Pattern advance on step, when mode_load=0:
  - OFF: pattern stays 0.
  - BLINK: pattern <= ~pattern (all LEDs toggle together).
  - CHASE: rotate left by 1; bit N_LEDS-1 wraps to bit0.
  - BOUNCE: shift in dir. At bit N_LEDS-1 with dir=up, dir flips to down and the next position is N_LEDS-2. Symmetrically at bit0 with dir=down. There is no dwell at the ends.
  - N_LEDS=1: CHASE and BOUNCE hold bit0 permanently.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps.
  - bright_r<=brightness only when pwm_cnt==0. This keeps the duty glitch-free, so a brightness change applies from the next PWM period.
  - pwm_on = (bright_r == all ones) OR (pwm_cnt < bright_r).
  - Brightness 0 forces dark. All ones gives 100% duty. Otherwise duty = bright_r / 2^PWM_BITS.
- Output: leds <= pattern AND replicate(pwm_on).
- Latency: the output is registered, so a pattern or PWM change shows on leds 1 cycle later.
- After reset, bright_r=0, so leds remain dark until brightness is sampled at the next pwm_cnt==0 and a non-OFF mode is loaded.
- Mode and brightness inputs are ignored between loads. Only mode_load changes mode_r.
- Reset mid-operation returns to OFF/dark on the same edge. No state survives reset.

Test Plan:
1. Bench parameters for scenarios 2-6: TICK_CYCLES=4, N_LEDS=8, PWM_BITS=4, brightness=15 unless stated. Reset: hold rst for 3 cycles with mode_load=1 and mode=2 -> leds=00, tick=0 throughout; after release with no load, leds stay 00 forever.
2. BLINK: load mode=1 at cycle T -> leds=FF at T+1; tick high at T+4 only; leds=00 from T+5; leds=FF from T+9; tick repeats every 4 cycles.
3. CHASE: load mode=2 -> leds steps through 01,02,04,...,80 then 01, each value held 4 cycles; tick is coincident with each step.
4. BOUNCE: load mode=3 -> leds steps through 01,02,...,80,40,20,...,01,02; 80 and 01 are each held for exactly one step.
5. PWM: BLINK with brightness=4, on-phase observed over 64 cycles with TICK_CYCLES=1000 -> leds=FF for 4 of every 16 cycles, aligned to pwm_cnt 0..3. brightness=0 -> leds always 00. brightness changed mid-period -> new duty only from the next pwm_cnt==0.
6. Simultaneous events: assert mode_load (mode=2) on the step cycle -> no advance, leds=01, next tick 4 cycles later. Assert rst while CHASE shows 10 -> leds=00 on the next cycle, then stays dark after rst is released.
